// File: rtl/multi_channel_tick_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_tick_counter_pkg
// Purpose  : Shared types and elaboration-time helpers for the tick counter
//            bank: FSM state encoding, channel-index width and the per-channel
//            reset seed.
// Revision : 1.0 - initial release
// ============================================================================
package multi_channel_tick_counter_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    // Channel select width: max(1, clog2(num_ch)).
    function automatic int ch_width(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

    // Reset value of channel idx; reversed order keeps the legacy display
    // layout (highest channel starts at zero).
    function automatic int seed(input int idx, input int num_ch, input int max_val);
        return (num_ch - 1 - idx) % (max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_channel_tick_counter_divider.sv
`default_nettype none
// ============================================================================
// Module   : tick_divider
// Purpose  : Divides clk by DIV = CLK_HZ/TICK_HZ (DIV >= 2) and emits a
//            one-cycle tick while enabled.
// Ports    : clk     - system clock, rising edge
//            reset_n - asynchronous active-low reset
//            en      - count enable; the divider only advances while high
//            tick    - high for the cycle in which the divider is at DIV-1
// Revision : 1.0 - initial release
// ============================================================================
module tick_divider #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    localparam int              c_div   = CLK_HZ / TICK_HZ;
    localparam int              c_div_w = $clog2(c_div);
    localparam logic [c_div_w-1:0] c_last = c_div_w'(c_div - 1);
    localparam logic [c_div_w-1:0] c_one  = c_div_w'(1);

    logic [c_div_w-1:0] r_div;

    // While disabled the divider parks at zero; its value is never observed
    // outside of an enabled period, and this guarantees every enable starts
    // a full DIV-cycle period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (!en) begin
            r_div <= '0;
        end else if (r_div == c_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_one;
        end
    end

    assign tick = en && (r_div == c_last);

endmodule
`default_nettype wire

// File: rtl/multi_channel_tick_counter.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_tick_counter
// Purpose  : Bank of NUM_CH counters advancing on a divided-down tick, with
//            run/stop, up/down, per-channel enable, wrap/saturate at MAX_VAL
//            and a valid/ready single-channel load port. data_raw feeds the
//            VGA text generator directly.
// Ports    : clk, reset_n        - clock / async active-low reset
//            run                 - level: 1 = RUN, 0 = STOP
//            clr                 - sync pulse, clears all channels
//            dir_down            - 0 = count up, 1 = count down
//            ch_en[NUM_CH]       - per-channel count enable
//            load_valid/ready    - load handshake (ready only in STOP)
//            load_ch, load_val   - load target channel and value
//            load_err            - pulse: load_ch out of range
//            tick                - pulse per count event
//            running             - high in RUN
//            data_raw            - packed channels, ch i at [i*CNT_W +: CNT_W]
//            frame_sync          - (optional) shadow update strobe
// Option   : MULTI_CHANNEL_TICK_COUNTER_FRAME_SYNC_EN adds frame_sync and
//            turns data_raw into a frame-synchronous shadow copy.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_tick_counter
    import multi_channel_tick_counter_pkg::*;
#(
    parameter  int CLK_HZ   = 100_000_000,
    parameter  int TICK_HZ  = 1,
    parameter  int NUM_CH   = 16,
    parameter  int CNT_W    = 16,
    parameter  int MAX_VAL  = 9999,
    parameter  int SATURATE = 0,
    localparam int CH_W     = ch_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    run,
    input  logic                    clr,
    input  logic                    dir_down,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [CH_W-1:0]         load_ch,
    input  logic [CNT_W-1:0]        load_val,
    output logic                    load_err,
    output logic                    tick,
    output logic                    running,
`ifdef MULTI_CHANNEL_TICK_COUNTER_FRAME_SYNC_EN
    input  logic                    frame_sync,
`endif
    output logic [NUM_CH*CNT_W-1:0] data_raw
);

    localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CH_W-1:0]          r_load_ch;
    logic [CNT_W-1:0]         r_load_val;
    logic                     w_accept;
    logic                     w_div_en;
    logic                     w_tick;
    logic                     w_ch_oob;
    logic                     w_load_we;
    logic [NUM_CH*CNT_W-1:0]  w_live;
    logic [NUM_CH*CNT_W-1:0]  w_seed;
    logic [NUM_CH*CNT_W-1:0]  r_data;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A load presented in STOP wins over run: load_ready is high for the
    // whole STOP state, so an offered load must be honoured once accepted.
    always_comb begin
        w_state_nxt = r_state;
        load_ready  = 1'b0;
        running     = 1'b0;
        case (r_state)
            ST_STOP: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    w_state_nxt = ST_LOAD;
                end else if (run) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                running = 1'b1;
                if (!run) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_STOP;
            end
            default: begin
                w_state_nxt = ST_STOP;
            end
        endcase
    end

    assign w_accept = load_valid && load_ready;

    // ------------------------------------------------------------------
    // Load capture (value clamped to MAX_VAL on acceptance)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_load_ch  <= '0;
            r_load_val <= '0;
        end else if (w_accept) begin
            r_load_ch  <= load_ch;
            r_load_val <= (load_val > c_max) ? c_max : load_val;
        end
    end

    // When NUM_CH fills the select space no index can be out of range.
    generate
        if (NUM_CH == (1 << CH_W)) begin : g_ch_full
            assign w_ch_oob = 1'b0;
        end else begin : g_ch_partial
            assign w_ch_oob = (int'(r_load_ch) >= NUM_CH);
        end
    endgenerate

    // clr in the LOAD cycle discards the pending load, including its error.
    assign w_load_we = (r_state == ST_LOAD) && !clr && !w_ch_oob;
    assign load_err  = (r_state == ST_LOAD) && !clr &&  w_ch_oob;

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
    assign w_div_en = (r_state == ST_RUN);

    tick_divider #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_div_en),
        .tick    (w_tick)
    );

    assign tick = w_tick;

    // ------------------------------------------------------------------
    // Counter array
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            localparam logic [CNT_W-1:0] c_seed = CNT_W'(seed(i, NUM_CH, MAX_VAL));

            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_step;

            always_comb begin
                w_step = r_cnt;
                if (dir_down) begin
                    if (r_cnt == '0) begin
                        w_step = (SATURATE != 0) ? r_cnt : c_max;
                    end else begin
                        w_step = r_cnt - c_one;
                    end
                end else begin
                    if (r_cnt == c_max) begin
                        w_step = (SATURATE != 0) ? r_cnt : '0;
                    end else begin
                        w_step = r_cnt + c_one;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= c_seed;
                end else if (clr) begin
                    r_cnt <= '0;
                end else if (w_tick && ch_en[i]) begin
                    r_cnt <= w_step;
                end else if (w_load_we && (r_load_ch == CH_W'(i))) begin
                    r_cnt <= r_load_val;
                end
            end

            assign w_live[i*CNT_W +: CNT_W] = r_cnt;
            assign w_seed[i*CNT_W +: CNT_W] = c_seed;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
`ifdef MULTI_CHANNEL_TICK_COUNTER_FRAME_SYNC_EN
    // Shadow copy refreshed only on frame_sync so a displayed frame never
    // mixes old and new counter values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= w_seed;
        end else if (frame_sync) begin
            r_data <= w_live;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= w_seed;
        end else begin
            r_data <= w_live;
        end
    end
`endif

    assign data_raw = r_data;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_tick_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_tick_counter
// Purpose  : Self-checking bench. Three instances share most stimulus:
//            dut_w (wrap, 4 ch), dut_s (saturate, 4 ch) and dut_e (3 ch, so
//            an out-of-range channel index is representable). Stimulus pushes
//            expected values tagged with the cycle they must hold in; a
//            monitor compares them on the falling edge.
// Option   : MULTI_CHANNEL_TICK_COUNTER_FRAME_SYNC_EN enables the shadow
//            register checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_tick_counter;

    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int CNT_W   = 8;
    localparam int MAX_VAL = 9;

    localparam int SEL_DR_W = 0;
    localparam int SEL_DR_S = 1;
    localparam int SEL_DR_E = 2;
    localparam int SEL_LR_W = 3;
    localparam int SEL_RN_W = 4;
    localparam int SEL_TK_W = 5;
    localparam int SEL_LE_W = 6;
    localparam int SEL_LR_S = 7;
    localparam int SEL_RN_S = 8;
    localparam int SEL_TK_S = 9;
    localparam int SEL_LE_S = 10;
    localparam int SEL_LR_E = 11;
    localparam int SEL_RN_E = 12;
    localparam int SEL_TK_E = 13;
    localparam int SEL_LE_E = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, clr, dir_down;
    logic [3:0]  ch_en;
    logic [1:0]  load_ch;
    logic [7:0]  load_val;
    logic        run_w, run_s, run_e, lv_w, lv_s, lv_e;
    logic        lr_w, lr_s, lr_e, le_w, le_s, le_e;
    logic        tk_w, tk_s, tk_e, rn_w, rn_s, rn_e;
    logic [31:0] dr_w, dr_s;
    logic [23:0] dr_e;
`ifdef MULTI_CHANNEL_TICK_COUNTER_FRAME_SYNC_EN
    logic        frame_sync;
`endif

    multi_channel_tick_counter #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_CH(4), .CNT_W(CNT_W),
        .MAX_VAL(MAX_VAL), .SATURATE(0)
    ) dut_w (
        .clk(clk), .reset_n(reset_n), .run(run_w), .clr(clr), .dir_down(dir_down),
        .ch_en(ch_en), .load_valid(lv_w), .load_ready(lr_w), .load_ch(load_ch),
        .load_val(load_val), .load_err(le_w), .tick(tk_w), .running(rn_w),
`ifdef MULTI_CHANNEL_TICK_COUNTER_FRAME_SYNC_EN
        .frame_sync(frame_sync),
`endif
        .data_raw(dr_w)
    );

    multi_channel_tick_counter #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_CH(4), .CNT_W(CNT_W),
        .MAX_VAL(MAX_VAL), .SATURATE(1)
    ) dut_s (
        .clk(clk), .reset_n(reset_n), .run(run_s), .clr(clr), .dir_down(dir_down),
        .ch_en(ch_en), .load_valid(lv_s), .load_ready(lr_s), .load_ch(load_ch),
        .load_val(load_val), .load_err(le_s), .tick(tk_s), .running(rn_s),
`ifdef MULTI_CHANNEL_TICK_COUNTER_FRAME_SYNC_EN
        .frame_sync(frame_sync),
`endif
        .data_raw(dr_s)
    );

    multi_channel_tick_counter #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_CH(3), .CNT_W(CNT_W),
        .MAX_VAL(MAX_VAL), .SATURATE(0)
    ) dut_e (
        .clk(clk), .reset_n(reset_n), .run(run_e), .clr(clr), .dir_down(dir_down),
        .ch_en(ch_en[2:0]), .load_valid(lv_e), .load_ready(lr_e), .load_ch(load_ch),
        .load_val(load_val), .load_err(le_e), .tick(tk_e), .running(rn_e),
`ifdef MULTI_CHANNEL_TICK_COUNTER_FRAME_SYNC_EN
        .frame_sync(frame_sync),
`endif
        .data_raw(dr_e)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          q_cyc[$];
    int          q_sel[$];
    logic [31:0] q_exp[$];
    string       q_name[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_DR_W: return dr_w;
            SEL_DR_S: return dr_s;
            SEL_DR_E: return {8'h00, dr_e};
            SEL_LR_W: return {31'd0, lr_w};
            SEL_RN_W: return {31'd0, rn_w};
            SEL_TK_W: return {31'd0, tk_w};
            SEL_LE_W: return {31'd0, le_w};
            SEL_LR_S: return {31'd0, lr_s};
            SEL_RN_S: return {31'd0, rn_s};
            SEL_TK_S: return {31'd0, tk_s};
            SEL_LE_S: return {31'd0, le_s};
            SEL_LR_E: return {31'd0, lr_e};
            SEL_RN_E: return {31'd0, rn_e};
            SEL_TK_E: return {31'd0, tk_e};
            SEL_LE_E: return {31'd0, le_e};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_at(input int dly, input int sel, input logic [31:0] exp,
                             input string name);
        q_cyc.push_back(cyc + dly);
        q_sel.push_back(sel);
        q_exp.push_back(exp);
        q_name.push_back(name);
    endtask

    always @(negedge clk) begin
        for (int i = q_cyc.size() - 1; i >= 0; i--) begin
            if (q_cyc[i] <= cyc) begin
                n_checks++;
                if (q_cyc[i] < cyc) begin
                    n_fail++;
                    $display("FAIL %s: due cycle %0d not evaluated, now %0d",
                             q_name[i], q_cyc[i], cyc);
                end else if (observe(q_sel[i]) !== q_exp[i]) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)",
                             q_name[i], observe(q_sel[i]), q_exp[i], cyc);
                end
                q_cyc.delete(i);
                q_sel.delete(i);
                q_exp.delete(i);
                q_name.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset_n  = 1'b0;
        clr      = 1'b0;
        dir_down = 1'b0;
        ch_en    = 4'h0;
        load_ch  = 2'd0;
        load_val = 8'd0;
        run_w = 1'b0; run_s = 1'b0; run_e = 1'b0;
        lv_w  = 1'b0; lv_s  = 1'b0; lv_e  = 1'b0;
`ifdef MULTI_CHANNEL_TICK_COUNTER_FRAME_SYNC_EN
        // Continuous sync makes the shadow behave like the plain register.
        frame_sync = 1'b1;
`endif
        step(3);
        reset_n = 1'b1;

        // Reset state: seeds ch0..ch3 = 3,2,1,0
        expect_at(0, SEL_DR_W, 32'h0001_0203, "reset data_raw w");
        expect_at(0, SEL_DR_S, 32'h0001_0203, "reset data_raw s");
        expect_at(0, SEL_DR_E, 32'h0000_0102, "reset data_raw e");
        expect_at(0, SEL_LR_W, 32'd1, "reset load_ready w");
        expect_at(0, SEL_LR_S, 32'd1, "reset load_ready s");
        expect_at(0, SEL_LR_E, 32'd1, "reset load_ready e");
        expect_at(0, SEL_RN_W, 32'd0, "reset running w");
        expect_at(0, SEL_RN_S, 32'd0, "reset running s");
        expect_at(0, SEL_RN_E, 32'd0, "reset running e");
        expect_at(0, SEL_LE_W, 32'd0, "reset load_err w");
        expect_at(0, SEL_LE_S, 32'd0, "reset load_err s");
        expect_at(0, SEL_LE_E, 32'd0, "reset load_err e");
        expect_at(0, SEL_TK_S, 32'd0, "reset tick s");
        expect_at(0, SEL_TK_E, 32'd0, "reset tick e");
        for (int d = 0; d < 50; d++) expect_at(d, SEL_TK_W, 32'd0, "idle no tick");
        step(50);

        // Count up, all channels; tick 10 cycles after run is raised
        ch_en    = 4'hF;
        dir_down = 1'b0;
        run_w    = 1'b1;
        expect_at(1, SEL_RN_W, 32'd1, "running after run");
        expect_at(1, SEL_LR_W, 32'd0, "load_ready low in run");
        for (int d = 1; d < 10; d++) expect_at(d, SEL_TK_W, 32'd0, "tick before period");
        expect_at(10, SEL_TK_W, 32'd1, "first tick");
        expect_at(11, SEL_TK_W, 32'd0, "tick single cycle");
        expect_at(12, SEL_DR_W, 32'h0102_0304, "one tick up");
        step(30);
        // Load offered while running must not be taken
        lv_w = 1'b1; load_ch = 2'd3; load_val = 8'd5;
        expect_at(0, SEL_LR_W, 32'd0, "no ready in run");
        step(1);
        lv_w = 1'b0;
        step(39);
        // run drops during the 7th tick cycle: the update still applies
        run_w = 1'b0;
        expect_at(0, SEL_TK_W, 32'd1, "seventh tick");
        expect_at(0, SEL_RN_W, 32'd1, "running in tick cycle");
        expect_at(1, SEL_RN_W, 32'd0, "running drops");
        expect_at(2, SEL_DR_W, 32'h0708_0900, "seven ticks wrap");
        expect_at(12, SEL_DR_W, 32'h0708_0900, "stopped holds");
        step(12);

        // Load ch2 = 15, clamped to 9
        lv_w = 1'b1; load_ch = 2'd2; load_val = 8'd15;
        expect_at(0, SEL_LR_W, 32'd1, "ready in stop");
        step(1);
        lv_w = 1'b0;
        expect_at(0, SEL_LR_W, 32'd0, "ready low in load");
        expect_at(0, SEL_LE_W, 32'd0, "no err valid load");
        expect_at(2, SEL_DR_W, 32'h0709_0900, "load clamp");
        step(3);

        // Out-of-range channel on the 3-channel instance
        lv_e = 1'b1; load_ch = 2'd3; load_val = 8'd5;
        step(1);
        lv_e = 1'b0;
        expect_at(0, SEL_LE_E, 32'd1, "load_err pulse");
        expect_at(1, SEL_LE_E, 32'd0, "load_err single cycle");
        expect_at(2, SEL_DR_E, 32'h0000_0102, "bad load no write");
        step(3);

        // Saturating down count: ch0 loaded with 1, others seeds 2,1,0
        dir_down = 1'b1;
        lv_s = 1'b1; load_ch = 2'd0; load_val = 8'd1;
        step(1);
        lv_s = 1'b0;
        step(1);
        run_s = 1'b1;
        expect_at(1, SEL_RN_S, 32'd1, "sat running");
        expect_at(12, SEL_DR_S, 32'h0000_0100, "sat one tick");
        expect_at(22, SEL_DR_S, 32'h0000_0000, "sat two ticks");
        expect_at(32, SEL_DR_S, 32'h0000_0000, "sat three ticks");
        expect_at(52, SEL_DR_S, 32'h0000_0000, "sat holds zero");
        step(53);
        run_s    = 1'b0;
        dir_down = 1'b0;
        step(2);

        // clr during the LOAD cycle of a pending ch1=5 load
        lv_w = 1'b1; load_ch = 2'd1; load_val = 8'd5;
        step(1);
        lv_w = 1'b0;
        clr  = 1'b1;
        expect_at(0, SEL_LE_W, 32'd0, "no err on clr");
        step(1);
        clr = 1'b0;
        expect_at(0, SEL_LR_W, 32'd1, "stop after clr");
        expect_at(0, SEL_RN_W, 32'd0, "not running after clr");
        expect_at(1, SEL_DR_W, 32'h0000_0000, "clr clears");
        expect_at(4, SEL_DR_W, 32'h0000_0000, "load discarded");
        step(5);

        // Masked channels: only ch0 and ch2 count, then down through zero
        ch_en = 4'b0101;
        run_w = 1'b1;
        expect_at(22, SEL_DR_W, 32'h0002_0002, "masked hold");
        step(22);
        dir_down = 1'b1;
        expect_at(30, SEL_DR_W, 32'h0009_0009, "down wrap");
        step(30);
        run_w = 1'b0;
        expect_at(10, SEL_DR_W, 32'h0009_0009, "hold after stop");
        step(12);
        dir_down = 1'b0;

`ifdef MULTI_CHANNEL_TICK_COUNTER_FRAME_SYNC_EN
        // Shadow frozen without frame_sync; one pulse captures live values
        frame_sync = 1'b0;
        ch_en      = 4'hF;
        run_w      = 1'b1;
        expect_at(25, SEL_DR_W, 32'h0009_0009, "shadow frozen");
        step(25);
        frame_sync = 1'b1;
        step(1);
        frame_sync = 1'b0;
        expect_at(0, SEL_DR_W, 32'h0201_0201, "shadow capture");
        expect_at(9, SEL_DR_W, 32'h0201_0201, "shadow holds");
        step(10);
        frame_sync = 1'b1;
`endif

        // Asynchronous reset in the middle of a run
        ch_en = 4'hF;
        run_w = 1'b1;
        step(15);
        reset_n = 1'b0;
        expect_at(0, SEL_DR_W, 32'h0001_0203, "async reset data_raw w");
        expect_at(0, SEL_RN_W, 32'd0, "async reset running");
        expect_at(0, SEL_LR_W, 32'd1, "async reset load_ready");
        expect_at(0, SEL_TK_W, 32'd0, "async reset tick");
        expect_at(0, SEL_DR_S, 32'h0001_0203, "async reset data_raw s");
        expect_at(0, SEL_DR_E, 32'h0000_0102, "async reset data_raw e");
        step(1);
        run_w = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(3);

        for (int i = 0; i < q_cyc.size(); i++) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: never evaluated (due cycle %0d)", q_name[i], q_cyc[i]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
